// File: rtl/qs_mq.sv
// qs_mq: queue selector between the input metadata stage and the queue buffers.
// Each metadata word is classified by type (and by the current time slot for
// TSN traffic) onto one of NUM_SLOT+2 queues. Words aimed at a full queue are
// dropped and counted per queue; words with an unknown type or out-of-range
// slot are counted as invalid. All outputs are registered (1-cycle latency).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_qs_time_slot     current time-slot index
//   in_qs_md            metadata {type[2:0], length[LEN_W-1:0], ptr[PTR_W-1:0]}
//   in_qs_md_wr         metadata valid (one cycle per word)
//   in_qs_q_full        per-queue full flags, bit i = queue i
//   in_qs_cnt_clr       clear all statistic counters
//   out_qs_md_ptr       pointer of emitted metadata (0 when no strobe)
//   out_qs_md_len       token length (non-zero only for rate-reserved traffic)
//   out_qs_md_wr        one-hot queue write strobe
//   out_qs_drop_cnt     saturating per-queue drop counters, queue i at [i*CNT_W +: CNT_W]
//   out_qs_inv_cnt      saturating invalid-metadata counter
module qs_mq #(
    parameter int unsigned NUM_SLOT  = 2,
    parameter int unsigned SLOT_W    = 1,
    parameter int unsigned PTR_W     = 9,
    parameter int unsigned LEN_W     = 12,
    parameter int unsigned HDR_BYTES = 32,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned NUM_Q    = NUM_SLOT + 2,
    localparam int unsigned MD_W     = PTR_W + LEN_W + 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SLOT_W-1:0]      in_qs_time_slot,
    input  logic [MD_W-1:0]        in_qs_md,
    input  logic                   in_qs_md_wr,
    input  logic [NUM_Q-1:0]       in_qs_q_full,
    input  logic                   in_qs_cnt_clr,
    output logic [PTR_W-1:0]       out_qs_md_ptr,
    output logic [LEN_W-1:0]       out_qs_md_len,
    output logic [NUM_Q-1:0]       out_qs_md_wr,
    output logic [NUM_Q*CNT_W-1:0] out_qs_drop_cnt,
    output logic [CNT_W-1:0]       out_qs_inv_cnt
);

    logic [2:0]       md_type;
    logic [LEN_W-1:0] md_len;
    logic [PTR_W-1:0] md_ptr;
    logic             tgt_valid;
    int unsigned      tgt_q;
    logic [LEN_W-1:0] tok_len;

    logic [NUM_Q-1:0]            wr_d, wr_q;
    logic [PTR_W-1:0]            ptr_d, ptr_q;
    logic [LEN_W-1:0]            len_d, len_q;
    logic [NUM_Q-1:0][CNT_W-1:0] drop_cnt_d, drop_cnt_q;
    logic [CNT_W-1:0]            inv_cnt_d, inv_cnt_q;

    // Classification: which queue a word targets and its token length.
    always_comb begin
        md_type   = in_qs_md[MD_W-1 -: 3];
        md_len    = in_qs_md[PTR_W +: LEN_W];
        md_ptr    = in_qs_md[PTR_W-1:0];
        tgt_valid = 1'b0;
        tgt_q     = 0;
        tok_len   = '0;
        case (md_type)
            3'd3: begin
                if (32'(in_qs_time_slot) < NUM_SLOT) begin
                    tgt_valid = 1'b1;
                    tgt_q     = 32'(in_qs_time_slot);
                end
            end
            3'd2: begin
                tgt_valid = 1'b1;
                tgt_q     = NUM_SLOT;
            end
            3'd1: begin
                tgt_valid = 1'b1;
                tgt_q     = NUM_SLOT;
                // Header bytes are not charged against the rate budget.
                tok_len   = (md_len >= LEN_W'(HDR_BYTES)) ? (md_len - LEN_W'(HDR_BYTES)) : '0;
            end
            3'd0: begin
                tgt_valid = 1'b1;
                tgt_q     = NUM_SLOT + 1;
            end
            default: begin
                tgt_valid = 1'b0;
            end
        endcase
    end

    // Strobe / drop / invalid decision and counter next-state.
    always_comb begin
        wr_d       = '0;
        ptr_d      = '0;
        len_d      = '0;
        drop_cnt_d = drop_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        if (in_qs_md_wr) begin
            if (tgt_valid) begin
                for (int unsigned i = 0; i < NUM_Q; i++) begin
                    if (i == tgt_q) begin
                        if (!in_qs_q_full[i]) begin
                            wr_d[i] = 1'b1;
                            ptr_d   = md_ptr;
                            len_d   = tok_len;
                        end else if (drop_cnt_q[i] != '1) begin
                            drop_cnt_d[i] = drop_cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end else if (inv_cnt_q != '1) begin
                inv_cnt_d = inv_cnt_q + CNT_W'(1);
            end
        end
        // Clear takes priority over any same-cycle increment.
        if (in_qs_cnt_clr) begin
            drop_cnt_d = '0;
            inv_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            ptr_q      <= '0;
            len_q      <= '0;
            drop_cnt_q <= '0;
            inv_cnt_q  <= '0;
        end else begin
            wr_q       <= wr_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            drop_cnt_q <= drop_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end

    assign out_qs_md_wr    = wr_q;
    assign out_qs_md_ptr   = ptr_q;
    assign out_qs_md_len   = len_q;
    assign out_qs_drop_cnt = drop_cnt_q;
    assign out_qs_inv_cnt  = inv_cnt_q;

endmodule

// File: tb/tb_qs_mq.sv
module tb_qs_mq;

    localparam int NS    = 4;
    localparam int SW    = 3;
    localparam int PW    = 9;
    localparam int LW    = 12;
    localparam int HB    = 32;
    localparam int CW    = 4;
    localparam int NQ    = NS + 2;
    localparam int MW    = PW + LW + 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SW-1:0]     in_qs_time_slot = '0;
    logic [MW-1:0]     in_qs_md = '0;
    logic              in_qs_md_wr = 1'b0;
    logic [NQ-1:0]     in_qs_q_full = '0;
    logic              in_qs_cnt_clr = 1'b0;
    logic [PW-1:0]     out_qs_md_ptr;
    logic [LW-1:0]     out_qs_md_len;
    logic [NQ-1:0]     out_qs_md_wr;
    logic [NQ*CW-1:0]  out_qs_drop_cnt;
    logic [CW-1:0]     out_qs_inv_cnt;

    qs_mq #(
        .NUM_SLOT (NS),
        .SLOT_W   (SW),
        .PTR_W    (PW),
        .LEN_W    (LW),
        .HDR_BYTES(HB),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_qs_time_slot(in_qs_time_slot),
        .in_qs_md       (in_qs_md),
        .in_qs_md_wr    (in_qs_md_wr),
        .in_qs_q_full   (in_qs_q_full),
        .in_qs_cnt_clr  (in_qs_cnt_clr),
        .out_qs_md_ptr  (out_qs_md_ptr),
        .out_qs_md_len  (out_qs_md_len),
        .out_qs_md_wr   (out_qs_md_wr),
        .out_qs_drop_cnt(out_qs_drop_cnt),
        .out_qs_inv_cnt (out_qs_inv_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Behavioural reference: expected outputs after each clock edge.
    int exp_wr = 0;
    int exp_ptr = 0;
    int exp_len = 0;
    int exp_drop [NQ];
    int exp_inv = 0;

    initial for (int i = 0; i < NQ; i++) exp_drop[i] = 0;

    always @(posedge clk) begin
        int typ, len, ptr, q;
        if (rst) begin
            exp_wr = 0; exp_ptr = 0; exp_len = 0; exp_inv = 0;
            for (int i = 0; i < NQ; i++) exp_drop[i] = 0;
        end else begin
            exp_wr = 0; exp_ptr = 0; exp_len = 0;
            if (in_qs_md_wr) begin
                typ = int'(in_qs_md[MW-1 -: 3]);
                len = int'(in_qs_md[PW +: LW]);
                ptr = int'(in_qs_md[PW-1:0]);
                q = -1;
                if (typ == 3 && int'(in_qs_time_slot) < NS) q = int'(in_qs_time_slot);
                else if (typ == 2) begin q = NS; len = 0; end
                else if (typ == 1) begin q = NS; len = (len < HB) ? 0 : len - HB; end
                else if (typ == 0) begin q = NS + 1; len = 0; end
                if (typ == 3) len = 0;
                if (q < 0) begin
                    if (exp_inv < CMAX) exp_inv++;
                end else if (in_qs_q_full[q]) begin
                    if (exp_drop[q] < CMAX) exp_drop[q]++;
                end else begin
                    exp_wr = 1 << q; exp_ptr = ptr; exp_len = len;
                end
            end
            if (in_qs_cnt_clr) begin
                exp_inv = 0;
                for (int i = 0; i < NQ; i++) exp_drop[i] = 0;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("wr", int'(out_qs_md_wr), exp_wr);
            cmp("ptr", int'(out_qs_md_ptr), exp_ptr);
            cmp("len", int'(out_qs_md_len), exp_len);
            cmp("inv_cnt", int'(out_qs_inv_cnt), exp_inv);
            for (int i = 0; i < NQ; i++)
                cmp($sformatf("drop_cnt[%0d]", i), int'(out_qs_drop_cnt[i*CW +: CW]), exp_drop[i]);
        end
    end

    // Present one cycle of inputs; returns #1 after the edge that captures them.
    task automatic cyc(input bit wr, input int typ, input int len, input int ptr,
                       input int slot, input int full, input bit clr, input bit r);
        in_qs_md_wr     = wr;
        in_qs_md        = {3'(typ), LW'(len), PW'(ptr)};
        in_qs_time_slot = SW'(slot);
        in_qs_q_full    = NQ'(full);
        in_qs_cnt_clr   = clr;
        rst             = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        cyc(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        cyc(1'b1, 3, 0, 9'h0AA, 1, 0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cmp("rst_wr", int'(out_qs_md_wr), 0);
        cmp("rst_drop", int'(out_qs_drop_cnt != '0), 0);
        cmp("rst_inv", int'(out_qs_inv_cnt), 0);

        // TSN word, slot 2
        cyc(1'b1, 3, 64, 9'h05A, 2, 0, 1'b0, 1'b0);
        cmp("tsn_wr", int'(out_qs_md_wr), 6'b000100);
        cmp("tsn_ptr", int'(out_qs_md_ptr), 9'h05A);
        idle();
        cmp("tsn_wr_after", int'(out_qs_md_wr), 0);
        cmp("tsn_ptr_after", int'(out_qs_md_ptr), 0);

        // Rate-reserved and PTP token lengths
        cyc(1'b1, 1, 100, 9'h1FF, 0, 0, 1'b0, 1'b0);
        cmp("rc_wr", int'(out_qs_md_wr), 6'b010000);
        cmp("rc_len", int'(out_qs_md_len), 68);
        cmp("rc_ptr", int'(out_qs_md_ptr), 9'h1FF);
        cyc(1'b1, 1, 20, 9'h003, 0, 0, 1'b0, 1'b0);
        cmp("rc_short_len", int'(out_qs_md_len), 0);
        cmp("rc_short_wr", int'(out_qs_md_wr), 6'b010000);
        cyc(1'b1, 2, 500, 9'h004, 0, 0, 1'b0, 1'b0);
        cmp("ptp_len", int'(out_qs_md_len), 0);
        cmp("ptp_wr", int'(out_qs_md_wr), 6'b010000);

        // Best effort into a full queue 5, three in a row
        repeat (3) cyc(1'b1, 0, 77, 9'h010, 0, 6'b100000, 1'b0, 1'b0);
        cmp("be_drop_wr", int'(out_qs_md_wr), 0);
        cmp("be_drop5", int'(out_qs_drop_cnt[5*CW +: CW]), 3);
        cmp("be_drop_others", int'(out_qs_drop_cnt[5*CW-1:0]), 0);

        // Invalid type and out-of-range slot
        cyc(1'b1, 5, 10, 9'h011, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 3, 10, 9'h012, 6, 0, 1'b0, 1'b0);
        cmp("inv_wr", int'(out_qs_md_wr), 0);
        cmp("inv_cnt", int'(out_qs_inv_cnt), 2);

        // Saturate queue 0 drops, then clear with a concurrent drop
        repeat (16) cyc(1'b1, 3, 0, 9'h020, 0, 6'b000001, 1'b0, 1'b0);
        cmp("sat_drop0", int'(out_qs_drop_cnt[0 +: CW]), 15);
        cyc(1'b1, 3, 0, 9'h021, 0, 6'b000001, 1'b0, 1'b0);
        cmp("sat_hold0", int'(out_qs_drop_cnt[0 +: CW]), 15);
        cyc(1'b1, 3, 0, 9'h022, 0, 6'b000001, 1'b1, 1'b0);
        cmp("clr_drop0", int'(out_qs_drop_cnt[0 +: CW]), 0);
        cmp("clr_inv", int'(out_qs_inv_cnt), 0);

        // Back-to-back mixed stream with reset mid-stream
        cyc(1'b1, 0, 40, 9'h030, 0, 6'b100000, 1'b0, 1'b0);
        cyc(1'b1, 6, 40, 9'h031, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 3, 40, 9'h032, 3, 0, 1'b0, 1'b0);
        cyc(1'b1, 1, 40, 9'h033, 0, 0, 1'b0, 1'b0);
        cmp("pre_rst_drop5", int'(out_qs_drop_cnt[5*CW +: CW]), 1);
        cyc(1'b1, 7, 40, 9'h034, 0, 0, 1'b0, 1'b1);
        cmp("mid_rst_wr", int'(out_qs_md_wr), 0);
        cmp("mid_rst_len", int'(out_qs_md_len), 0);
        cmp("mid_rst_drop", int'(out_qs_drop_cnt != '0), 0);
        cyc(1'b1, 0, 40, 9'h035, 0, 6'b100000, 1'b0, 1'b1);
        cmp("mid_rst_inv", int'(out_qs_inv_cnt), 0);
        cyc(1'b1, 3, 40, 9'h036, 1, 0, 1'b0, 1'b0);
        cmp("post_rst_wr", int'(out_qs_md_wr), 6'b000010);
        cyc(1'b1, 0, 40, 9'h037, 0, 0, 1'b0, 1'b0);
        cmp("post_rst_be", int'(out_qs_md_wr), 6'b100000);
        cmp("post_rst_drop", int'(out_qs_drop_cnt != '0), 0);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 9) != 0),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 511)),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 63) & $urandom_range(0, 63)),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 99) == 0));
        end
        idle();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qs_mq.md
# qs_mq

Parametrised queue selector for the TSN switch pipeline, between the IBM (input metadata) and the MB (queue buffers). Classifies each metadata word by traffic type and time slot onto one of NUM_SLOT+2 output queues, computes token length for rate-limited traffic, and drops metadata aimed at a full queue. Keeps saturating per-queue drop counters and an invalid-metadata counter for management readout. Generalises the fixed 2-slot/4-queue selector to N slots with per-queue backpressure.

## Interface
- NUM_SLOT, 2, number of time-slot TSN queues (≥2); queues 0..NUM_SLOT-1 are TSN
- SLOT_W, 1, width of slot index (2^SLOT_W ≥ NUM_SLOT)
- PTR_W, 9, buffer pointer width
- LEN_W, 12, packet length field width (bytes)
- HDR_BYTES, 32, bytes subtracted from rate-class length (2 metadata cycles)
- CNT_W, 16, statistic counter width
- Derived: NUM_Q = NUM_SLOT+2; MD_W = PTR_W+LEN_W+3
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_qs_time_slot  in  SLOT_W  current slot index from LCM
- in_qs_md  in  MD_W  metadata: [MD_W-1:MD_W-3] type, [PTR_W+LEN_W-1:PTR_W] length, [PTR_W-1:0] pointer
- in_qs_md_wr  in  1  metadata valid, single cycle per word
- in_qs_q_full  in  NUM_Q  per-queue full from MB, bit i = queue i
- in_qs_cnt_clr  in  1  clear all counters
- out_qs_md_ptr  out  PTR_W  pointer of emitted metadata
- out_qs_md_len  out  LEN_W  token length (valid only for queue NUM_SLOT)
- out_qs_md_wr  out  NUM_Q  one-hot write strobe, bit i = queue i
- out_qs_drop_cnt  out  NUM_Q*CNT_W  per-queue drop counts, queue i at [i*CNT_W +: CNT_W]
- out_qs_inv_cnt  out  CNT_W  invalid-metadata count

## Operation
- Queue mapping on in_qs_md_wr=1:
  - type 3: queue = in_qs_time_slot; slot ≥ NUM_SLOT → invalid
  - type 2 (PTP): queue NUM_SLOT, len = 0 (no token consumption)
  - type 1 (rate-reserved): queue NUM_SLOT, len = length − HDR_BYTES, saturating at 0 (length < HDR_BYTES → 0)
  - type 0 (best effort): queue NUM_SLOT+1, len = 0
  - types 4–7: invalid
- Valid target with in_qs_q_full[q]=0: assert out_qs_md_wr[q], drive ptr/len.
- Valid target with in_qs_q_full[q]=1: no strobe, ptr/len = 0, drop_cnt[q] += 1.
- Invalid: no strobe, outputs 0, inv_cnt += 1.
- No in_qs_md_wr: out_qs_md_wr = 0, ptr = 0, len = 0.
- Counters saturate at 2^CNT_W−1, never wrap.
- in_qs_cnt_clr=1: all counters 0 next cycle; clear wins over a same-cycle increment (event not counted).
- Slot and full sampled in the same cycle as in_qs_md_wr; no registered slot state.

## Timing
- Latency 1 cycle: metadata at edge n → strobe/ptr/len valid after edge n+1, for one cycle only.
- Back-to-back metadata every cycle supported; each produces exactly one strobe, drop or invalid count.
- out_qs_md_wr at most one bit set per cycle.
- Counters update on the same edge as the corresponding (suppressed) output.
- Reset: all outputs and counters 0 on the first edge with rst=1; metadata arriving while rst=1 is discarded uncounted; in-flight output cleared.

## Test plan
- Reset, then NUM_SLOT=4: type 3, ptr 0x05A, slot 2 → out_qs_md_wr=4'b0100 (bits 0..5 = 000100), ptr 0x05A, next cycle all 0.
- Type 1, length 100, ptr 0x1FF → wr bit 4 set, len 68; length 20 → len 0; type 2 length 500 → len 0.
- Type 0 with in_qs_q_full[5]=1, three consecutive words → no strobes, drop_cnt[5]=3, others 0.
- Type 5 word and type 3 with slot 6 (NUM_SLOT=4) → no strobes, inv_cnt=2.
- Preload drop_cnt[0] to saturation (CNT_W=4, 16 drops) → stays 15; assert in_qs_cnt_clr with a drop same cycle → 0.
- Stream 8 mixed words back-to-back, rst pulsed mid-stream → outputs 0 next edge, counters 0, words during rst not counted.
